dac_player: RTL and testbench
=============================

# dac_player

Sample-playback controller driving the external R-2R ladder DAC, the output-direction counterpart of the SAR converter path. Accepts RESOLUTION-bit codes over a valid/ready stream, buffers them in a small FIFO, and presents one code to the ladder per sample period set by a programmable clock divider. Reports buffer level and flags underruns, when a sample period elapses with no data queued.

## Interface
- RESOLUTION, 16, DAC code width in bits.
- FIFO_DEPTH, 8, sample buffer entries; power of two, ≥2.
- DIV_WIDTH, 16, width of the sample-period divider.
- clk_i  input  1  system clock.
- rst_i  input  1  reset, asynchronous, active-high.
- en_i  input  1  playback enable.
- div_i  input  DIV_WIDTH  sample period minus one, in clk_i cycles.
- data_i  input  RESOLUTION  sample code.
- valid_i  input  1  data_i valid.
- ready_o  output  1  FIFO can accept a sample.
- clr_underrun_i  input  1  clears underrun_o.
- dac_o  output  RESOLUTION  registered code to the R-2R ladder.
- update_o  output  1  one-cycle pulse, high in the cycle dac_o takes a new code.
- underrun_o  output  1  sticky underrun flag.
- level_o  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy, 0..FIFO_DEPTH.

## Operation
- Push: valid_i && ready_o at a clk_i edge writes data_i to the FIFO tail. ready_o = (level < FIFO_DEPTH), combinational from registered level only.
- Divider: counter cnt, DIV_WIDTH bits. With en_i=1: tick when cnt >= div_i, then cnt <= 0; otherwise cnt <= cnt+1. Using >= means lowering div_i below cnt gives an immediate tick, never a wrap-around.
- With en_i=0: cnt held at 0, no ticks. FIFO still accepts pushes. dac_o holds its value.
- Tick with level>0: pop head, dac_o <= head, update_o <= 1.
- Tick with level=0: no pop, underrun_o <= 1. dac_o behaves as set under Configuration.
- Same-edge push and pop: level unchanged. A push into an empty FIFO is not visible to a tick in the same cycle; that tick is an underrun.
- clr_underrun_i=1 clears underrun_o. A simultaneous new underrun wins, so the flag stays 1.
- level_o tracks pushes minus pops. Pointers wrap modulo FIFO_DEPTH.
- Mid-operation reset: FIFO is emptied, counter is cleared, in-flight data is discarded.

## Timing
- Reset values: dac_o=0, update_o=0, underrun_o=0, level_o=0, ready_o=1, cnt=0.
- Sample period is div_i+1 cycles. div_i=0 gives a tick every cycle, so one sample per cycle with continuous input, with no bubble.
- Latency: after en_i rises with cnt=0, the first tick occurs div_i cycles later. dac_o and update_o are registered and change on the tick edge.
- Push-to-output latency, FIFO empty and ticking: at least 1 cycle, at most div_i+1 cycles.
- Full: ready_o=0 the cycle after level reaches FIFO_DEPTH. ready_o returns to 1 the cycle after a pop.

## Configuration
- DAC_UNDERRUN_MIDSCALE_EN defined: an underrun tick sets dac_o <= 2^(RESOLUTION-1) (0x8000 at 16 bits) and pulses update_o.
- DAC_UNDERRUN_MIDSCALE_EN undefined: dac_o holds the last code, and update_o stays 0 on an underrun tick.
- Reset value of dac_o is 0 in both builds.

## Test plan
- Reset, then div_i=3, en_i=1, push 0x0001, 0x0002, 0x0003 back-to-back -> dac_o steps 0x0001, 0x0002, 0x0003 on ticks 4 cycles apart; update_o pulses 3 times; level_o returns to 0.
- Push 9 samples with en_i=0 and FIFO_DEPTH=8 -> ready_o=0 after 8 accepted; 9th held; level_o=8; dac_o stays 0.
- div_i=0, continuous stream 0x1000..0x100F -> dac_o changes every cycle, with no underrun while the stream keeps pace.
- Let the FIFO drain with div_i=2 -> next tick sets underrun_o=1. Without the macro, dac_o holds its last value; with it, dac_o=0x8000. clr_underrun_i pulse -> underrun_o=0.
- Mid-stream, div_i 100->5 with cnt=50 -> tick next cycle, then a period of 6 cycles.
- Assert rst_i asynchronously between edges with level_o=5 -> all outputs take reset values immediately, with no update_o pulse.

Source files
------------

// File: rtl/dac_player.sv
// Sample-playback controller for the R-2R ladder DAC: stream-in FIFO, sample-period divider, underrun flag.
// Optional DAC_UNDERRUN_MIDSCALE_EN: an underrun tick drives the ladder to midscale instead of holding.
module dac_player #(
    parameter int RESOLUTION = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [DIV_WIDTH-1:0]          div_i,
    input  logic [RESOLUTION-1:0]         data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic                          clr_underrun_i,
    output logic [RESOLUTION-1:0]         dac_o,
    output logic                          update_o,
    output logic                          underrun_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
`ifdef DAC_UNDERRUN_MIDSCALE_EN
    localparam logic [RESOLUTION-1:0] MIDSCALE = {1'b1, {(RESOLUTION-1){1'b0}}};
`endif

    logic [RESOLUTION-1:0] mem_q [FIFO_DEPTH];
    logic [RESOLUTION-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [RESOLUTION-1:0] dac_q, dac_d;
    logic                  update_q, update_d;
    logic                  underrun_q, underrun_d;
    logic                  tick, push, pop, empty_tick;

    assign ready_o    = (level_q < LW'(FIFO_DEPTH));
    assign level_o    = level_q;
    assign dac_o      = dac_q;
    assign update_o   = update_q;
    assign underrun_o = underrun_q;

    always_comb begin
        // >= rather than == so shrinking div_i below cnt ticks at once instead of wrapping
        tick       = en_i && (cnt_q >= div_i);
        push       = valid_i && ready_o;
        pop        = tick && (level_q != '0);
        empty_tick = tick && (level_q == '0);

        cnt_d = '0;
        if (en_i && !tick) begin
            cnt_d = cnt_q + 1'b1;
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        dac_d    = dac_q;
        update_d = 1'b0;
        if (pop) begin
            dac_d    = mem_q[rd_ptr_q];
            update_d = 1'b1;
        end
`ifdef DAC_UNDERRUN_MIDSCALE_EN
        else if (empty_tick) begin
            dac_d    = MIDSCALE;
            update_d = 1'b1;
        end
`endif

        // a fresh underrun outranks a clear in the same cycle
        if (empty_tick) begin
            underrun_d = 1'b1;
        end else if (clr_underrun_i) begin
            underrun_d = 1'b0;
        end else begin
            underrun_d = underrun_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            dac_q      <= '0;
            update_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            dac_q      <= dac_d;
            update_q   <= update_d;
            underrun_q <= underrun_d;
        end
    end
endmodule

// File: tb/tb_dac_player.sv
// Self-checking bench for dac_player: vector table for FIFO fill, scoreboard for output codes, hand sequences for timing corners.
module tb_dac_player;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b0;
    logic [15:0] div_i = '0;
    logic [15:0] data_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic        clr_underrun_i = 1'b0;
    logic [15:0] dac_o;
    logic        update_o;
    logic        underrun_o;
    logic [3:0]  level_o;

    int n_checks = 0;
    int n_fail = 0;

    dac_player dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .div_i(div_i),
        .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
        .clr_underrun_i(clr_underrun_i), .dac_o(dac_o), .update_o(update_o),
        .underrun_o(underrun_o), .level_o(level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_upd(input string name, input int maxc, output int c);
        c = 0;
        do begin
            step();
            c++;
        end while (!update_o && c < maxc);
        chk(name, update_o, 1'b1);
    endtask

    // Scoreboard: accepted pushes become expected codes, consumed on each update_o.
    logic [15:0] exp_q[$];
    logic        pend_v = 1'b0;
    logic [15:0] pend_d = '0;

    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
            pend_v = 1'b0;
        end else begin
            if (update_o) begin
                if (exp_q.size() > 0) begin
                    chk("sb_dac", dac_o, exp_q.pop_front());
                end else begin
`ifdef DAC_UNDERRUN_MIDSCALE_EN
                    chk("sb_midscale", dac_o, 16'h8000);
`else
                    chk("sb_spurious_update", update_o, 1'b0);
`endif
                end
            end
            if (pend_v) exp_q.push_back(pend_d);
            pend_v = valid_i && ready_o;
            pend_d = data_i;
        end
    end

    typedef struct {
        logic [15:0] data;
        logic [3:0]  exp_level;
        logic        exp_ready;
    } vec_t;
    vec_t fill_tab[9];

    task automatic do_reset();
        rst_i = 1'b1; en_i = 1'b0; valid_i = 1'b0; clr_underrun_i = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        step();
    endtask

    initial begin
        int c, n;
        for (int i = 0; i < 9; i++) begin
            fill_tab[i].data      = 16'h0A00 + 16'(i);
            fill_tab[i].exp_level = (i < 8) ? 4'(i + 1) : 4'd8;
            fill_tab[i].exp_ready = (i < 7);
        end

        do_reset();
        chk("rst_dac", dac_o, 16'h0);
        chk("rst_update", update_o, 1'b0);
        chk("rst_underrun", underrun_o, 1'b0);
        chk("rst_level", level_o, 4'd0);
        chk("rst_ready", ready_o, 1'b1);

        // Three back-to-back pushes, period 4
        div_i = 16'd3; en_i = 1'b1; valid_i = 1'b1; data_i = 16'h0001;
        step(); data_i = 16'h0002;
        step(); data_i = 16'h0003;
        step(); valid_i = 1'b0;
        wait_upd("b_first_upd", 10, c);
        wait_upd("b_second_upd", 10, c);
        chk("b_gap1", c, 4);
        wait_upd("b_third_upd", 10, c);
        chk("b_gap2", c, 4);
        chk("b_dac3", dac_o, 16'h0003);
        chk("b_level0", level_o, 4'd0);
        en_i = 1'b0;

        // Fill with playback disabled
        do_reset();
        for (int i = 0; i < 9; i++) begin
            valid_i = 1'b1; data_i = fill_tab[i].data;
            step();
            chk($sformatf("fill_level_%0d", i), level_o, fill_tab[i].exp_level);
            chk($sformatf("fill_ready_%0d", i), ready_o, fill_tab[i].exp_ready);
        end
        valid_i = 1'b0;
        chk("fill_dac_hold", dac_o, 16'h0);
        div_i = 16'd0; en_i = 1'b1;
        step();
        chk("fill_pop_level", level_o, 4'd7);
        chk("fill_pop_ready", ready_o, 1'b1);
        for (int i = 0; i < 7; i++) step();
        en_i = 1'b0;
        step();
        chk("fill_drained", level_o, 4'd0);
        chk("fill_last_dac", dac_o, 16'h0A07);

        // Continuous stream at one sample per cycle
        do_reset();
        div_i = 16'd0; valid_i = 1'b1; data_i = 16'h1000;
        n = 0;
        for (int i = 0; i <= 16; i++) begin
            step();
            if (update_o) n++;
            if (i == 0) en_i = 1'b1;
            if (i < 15) data_i = 16'h1001 + 16'(i);
            else valid_i = 1'b0;
        end
        en_i = 1'b0;
        chk("stream_updates", n, 16);
        chk("stream_no_underrun", underrun_o, 1'b0);
        chk("stream_last", dac_o, 16'h100F);

        // Drain to underrun, then clear
        do_reset();
        div_i = 16'd2; valid_i = 1'b1; data_i = 16'h00AA;
        step();
        valid_i = 1'b0; en_i = 1'b1;
        wait_upd("d_upd", 10, c);
        chk("d_no_underrun_yet", underrun_o, 1'b0);
        c = 0;
        do begin
            step();
            c++;
        end while (!underrun_o && c < 10);
        chk("d_underrun_set", underrun_o, 1'b1);
        chk("d_underrun_delay", c, 3);
`ifdef DAC_UNDERRUN_MIDSCALE_EN
        chk("d_dac_midscale", dac_o, 16'h8000);
`else
        chk("d_dac_hold", dac_o, 16'h00AA);
`endif
        div_i = 16'd0; clr_underrun_i = 1'b1;
        step();
        chk("d_clr_loses_to_underrun", underrun_o, 1'b1);
        en_i = 1'b0;
        step();
        chk("d_clr", underrun_o, 1'b0);
        clr_underrun_i = 1'b0;

        // Divider shrink below running count
        do_reset();
        valid_i = 1'b1; data_i = 16'h0B01;
        step(); data_i = 16'h0B02;
        step(); valid_i = 1'b0;
        div_i = 16'd100; en_i = 1'b1;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (update_o) n++;
        end
        chk("f_no_tick_before", n, 0);
        div_i = 16'd5;
        step();
        chk("f_immediate_tick", update_o, 1'b1);
        chk("f_dac1", dac_o, 16'h0B01);
        wait_upd("f_second_upd", 20, c);
        chk("f_period6", c, 6);
        en_i = 1'b0;

        // Asynchronous reset between edges with data buffered
        for (int i = 0; i < 5; i++) begin
            valid_i = 1'b1; data_i = 16'h0C00 + 16'(i);
            step();
        end
        valid_i = 1'b0;
        chk("g_level5", level_o, 4'd5);
        #3 rst_i = 1'b1;
        #1;
        chk("g_rst_level", level_o, 4'd0);
        chk("g_rst_ready", ready_o, 1'b1);
        chk("g_rst_dac", dac_o, 16'h0);
        chk("g_rst_update", update_o, 1'b0);
        chk("g_rst_underrun", underrun_o, 1'b0);
        step();
        chk("g_rst_hold_update", update_o, 1'b0);
        rst_i = 1'b0;
        step();
        chk("g_post_level", level_o, 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
